mul_8_seq: RTL

MUL_8_SEQ -- requirements
Module: mul_8_seq

---
 rtl/mul_8_seq.sv | 111 +++++++++++
 1 files changed

// File: rtl/mul_8_seq.sv
// Sequential 8x8 unsigned multiplier: shift-and-add over 8 clock cycles,
// valid/ready handshake on both the operand and the product side.
module mul_8_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] p
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  mcand_q, mcand_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  lo_q, lo_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        out_valid_q, out_valid_d;
  logic [8:0]  add_s;

  // 8-bit ripple-carry adder; bit 8 of the result is the carry-out.
  function automatic logic [8:0] rca8(input logic [7:0] x, input logic [7:0] y);
    logic [8:0] r;
    logic       c;
    r = 9'd0;
    c = 1'b0;
    for (int i = 0; i < 8; i++) begin
      r[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    r[8] = c;
    return r;
  endfunction

  // Next-state and datapath update for the IDLE/RUN/DONE controller.
  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    add_s       = lo_q[0] ? rca8(hi_q, mcand_q) : {1'b0, hi_q};
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          mcand_d = a;
          lo_d    = b;
          hi_d    = 8'd0;
          cnt_d   = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Carry-out shifts into hi so no product bit is lost.
        hi_d  = add_s[8:1];
        lo_d  = {add_s[0], lo_q[7:1]};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mcand_q     <= 8'd0;
      hi_q        <= 8'd0;
      lo_q        <= 8'd0;
      cnt_q       <= 3'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign p         = {hi_q, lo_q};

endmodule
